ext_trig_arbiter: RTL

EXT_TRIG_ARBITER -- requirements
Module: ext_trig_arbiter

---
 rtl/trig_pkg.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/ext_trig_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the external trigger arbiter.
//   trig_state_t : IDLE / FIRE / DEAD state encoding
//   SRC_*        : fire_src codes (none, coincidence, software, rolling)
//   dur_load     : converts a duration in ticks into the down-counter load value
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_DEAD = 2'd2
  } trig_state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_COINC = 2'd1;
  localparam logic [1:0] SRC_SW    = 2'd2;
  localparam logic [1:0] SRC_ROLL  = 2'd3;

  // The duration counter counts down to zero inclusive, so a phase lasting
  // N ticks is loaded with N-1.
  function automatic logic [7:0] dur_load(input logic [7:0] ticks);
    return ticks - 8'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter.
//   clk_adc : clock
//   nrst    : asynchronous active-low reset
//   inc     : count one event this tick
//   clr     : synchronous clear, wins over inc
//   q       : registered count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_adc,
  input  logic         nrst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count register with clear priority and saturation.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1'b1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ext_trig_arbiter.sv
// External trigger arbiter: picks one of coincidence, software or rolling
// requests, emits a fixed-width trigger pulse followed by a dead time, and
// keeps saturating statistics.
//   clk_adc, nrst        : clock, asynchronous active-low reset
//   enable               : allows new fires (running sequences always finish)
//   coinc_req            : level coincidence request
//   sw_req               : single-tick software request (latched as pending)
//   dorolling            : enables periodic rolling fires
//   randnum, prescale    : coincidence accepted when randnum <= prescale
//   clr_counters         : clears the statistics counters
//   ext_trig_out         : trigger pulse, PULSE_W ticks
//   busy                 : high in FIRE and DEAD
//   fire_src             : source of the current/last fire
//   n_fired, n_veto_dead, n_veto_presc : statistics
module ext_trig_arbiter
  import trig_pkg::*;
#(
  parameter int PULSE_W    = 4,
  parameter int DEAD_TICKS = 20,
  parameter int ROLL_BIT   = 25,
  parameter int CNT_W      = 32
) (
  input  logic             clk_adc,
  input  logic             nrst,
  input  logic             enable,
  input  logic             coinc_req,
  input  logic             sw_req,
  input  logic             dorolling,
  input  logic [31:0]      randnum,
  input  logic [31:0]      prescale,
  input  logic             clr_counters,
  output logic             ext_trig_out,
  output logic             busy,
  output logic [1:0]       fire_src,
  output logic [CNT_W-1:0] n_fired,
  output logic [CNT_W-1:0] n_veto_dead,
  output logic [CNT_W-1:0] n_veto_presc
);

  localparam int RW = ROLL_BIT + 1;
  localparam logic [7:0] PULSE_LOAD = dur_load(8'(PULSE_W));
  localparam logic [7:0] DEAD_LOAD  = dur_load(8'(DEAD_TICKS));

  trig_state_t    state_r;
  logic [7:0]     cnt_r;
  logic [31:0]    prescale_q;
  logic           pass_r;
  logic [RW-1:0]  roll_r;
  logic           sw_pend_r;

  logic roll_req_s;
  logic idle_go_s;
  logic coinc_win_s;
  logic sw_win_s;
  logic roll_win_s;
  logic coinc_fire_s;
  logic coinc_rej_s;
  logic fire_s;
  logic veto_dead_s;

  // Fixed priority among requests seen in IDLE: coinc, then sw pending, then roll.
  assign roll_req_s   = roll_r[ROLL_BIT] & dorolling;
  assign idle_go_s    = (state_r == ST_IDLE) & enable;
  assign coinc_win_s  = idle_go_s & coinc_req;
  assign sw_win_s     = idle_go_s & ~coinc_req & sw_pend_r;
  assign roll_win_s   = idle_go_s & ~coinc_req & ~sw_pend_r & roll_req_s;
  assign coinc_fire_s = coinc_win_s & pass_r;
  assign coinc_rej_s  = coinc_win_s & ~pass_r;
  assign fire_s       = coinc_fire_s | sw_win_s | roll_win_s;
  assign veto_dead_s  = (state_r != ST_IDLE) & coinc_req;

  // Prescale threshold register and registered pass decision.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      prescale_q <= 32'd0;
      pass_r     <= 1'b0;
    end else begin
      prescale_q <= prescale;
      pass_r     <= (randnum <= prescale_q);
    end
  end

  // Rolling timer: free-running, restarts when its request bit appears or on a coinc fire.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      roll_r <= '0;
    end else if (coinc_fire_s || roll_r[ROLL_BIT]) begin
      roll_r <= '0;
    end else begin
      roll_r <= roll_r + RW'(1'b1);
    end
  end

  // One-deep software pending flag; a new request on the consuming tick keeps it set.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      sw_pend_r <= 1'b0;
    end else if (sw_req) begin
      sw_pend_r <= 1'b1;
    end else if (sw_win_s) begin
      sw_pend_r <= 1'b0;
    end else begin
      sw_pend_r <= sw_pend_r;
    end
  end

  // Main sequencer with registered pulse, busy and source outputs.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      ext_trig_out <= 1'b0;
      busy         <= 1'b0;
      fire_src     <= SRC_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            state_r      <= ST_FIRE;
            cnt_r        <= PULSE_LOAD;
            ext_trig_out <= 1'b1;
            busy         <= 1'b1;
            if (coinc_fire_s) begin
              fire_src <= SRC_COINC;
            end else if (sw_win_s) begin
              fire_src <= SRC_SW;
            end else begin
              fire_src <= SRC_ROLL;
            end
          end else if (coinc_rej_s) begin
            // Prescale-rejected coincidence still costs a dead period, silently.
            state_r      <= ST_DEAD;
            cnt_r        <= DEAD_LOAD;
            ext_trig_out <= 1'b0;
            busy         <= 1'b1;
          end else begin
            ext_trig_out <= 1'b0;
            busy         <= 1'b0;
          end
        end
        ST_FIRE: begin
          if (cnt_r == 8'd0) begin
            state_r      <= ST_DEAD;
            cnt_r        <= DEAD_LOAD;
            ext_trig_out <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_DEAD: begin
          if (cnt_r == 8'd0) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 8'd0;
          ext_trig_out <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_n_fired (
    .clk_adc (clk_adc),
    .nrst    (nrst),
    .inc     (fire_s),
    .clr     (clr_counters),
    .q       (n_fired)
  );

  sat_counter #(.W(CNT_W)) u_n_veto_dead (
    .clk_adc (clk_adc),
    .nrst    (nrst),
    .inc     (veto_dead_s),
    .clr     (clr_counters),
    .q       (n_veto_dead)
  );

  sat_counter #(.W(CNT_W)) u_n_veto_presc (
    .clk_adc (clk_adc),
    .nrst    (nrst),
    .inc     (coinc_rej_s),
    .clr     (clr_counters),
    .q       (n_veto_presc)
  );

endmodule
